// File: rtl/mux41_scan_ctrl.sv
// rtl/mux41_scan_ctrl.sv - round-robin scanner driving a 4:1 mux select and emitting tagged samples
module mux41_scan_ctrl #(
    parameter int DW         = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic [3:0]    i_ch_mask,
    output logic [1:0]    o_sel,
    input  logic [DW-1:0] i_y,
    output logic [DW-1:0] o_data,
    output logic [1:0]    o_ch,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_busy
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    ptr_q;
    logic [1:0]    sel_q;
    logic [DW-1:0] data_q;
    logic [1:0]    ch_q;
    logic          valid_q;

    logic [1:0]    pick_idle_d;
    logic [1:0]    pick_hold_d;
    logic          scan_ok;

    // First enabled channel at or above 'from', wrapping 3->0; the lowest offset wins.
    function automatic logic [1:0] pick(input logic [1:0] from, input logic [3:0] mask);
        logic [1:0] p;
        logic [1:0] idx;
        p = from;
        for (int k = 3; k >= 0; k--) begin
            idx = from + 2'(k);
            if (mask[idx]) p = idx;
        end
        return p;
    endfunction

    assign scan_ok     = i_en && (i_ch_mask != 4'd0);
    assign pick_idle_d = pick(ptr_q, i_ch_mask);
    assign pick_hold_d = pick(sel_q + 2'd1, i_ch_mask);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            data_q  <= '0;
            ch_q    <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scan_ok) begin
                        sel_q   <= pick_idle_d;
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!i_en) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        data_q  <= i_y;
                        ch_q    <= sel_q;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        ptr_q   <= sel_q + 2'd1;
                        if (scan_ok) begin
                            // Settle time restarts even if the same channel is picked again.
                            sel_q   <= pick_hold_d;
                            cnt_q   <= '0;
                            state_q <= SETTLE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_sel   = sel_q;
    assign o_data  = data_q;
    assign o_ch    = ch_q;
    assign o_valid = valid_q;
    assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mux41_scan_ctrl.sv
// tb/tb_mux41_scan_ctrl.sv - scoreboard bench for mux41_scan_ctrl
module tb_mux41_scan_ctrl;

    localparam int DW         = 8;
    localparam int SETTLE_CYC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [3:0]    mask;
    logic [1:0]    sel;
    logic [DW-1:0] y;
    logic [DW-1:0] data;
    logic [1:0]    ch;
    logic          valid;
    logic          ready;
    logic          busy;

    logic [DW-1:0] d_arr [4];
    logic [9:0]    exp_q [$];
    int            rise_q [$];
    int            hs_q [$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            sel_bad = 0;
    bit            mask_mon = 1'b0;
    logic          valid_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign y = d_arr[sel];

    mux41_scan_ctrl #(.DW(DW), .SETTLE_CYC(SETTLE_CYC)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en),
        .i_ch_mask(mask),
        .o_sel    (sel),
        .i_y      (y),
        .o_data   (data),
        .o_ch     (ch),
        .o_valid  (valid),
        .i_ready  (ready),
        .o_busy   (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_d(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] e);
        d_arr[0] = a;
        d_arr[1] = b;
        d_arr[2] = c;
        d_arr[3] = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!valid && n < 100) begin
            tick();
            n++;
        end
        check(tag, {31'd0, valid}, 32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check(tag, exp_q.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            logic [9:0] e;
            if (valid && !valid_prev) rise_q.push_back(cyc);
            if (valid && ready) begin
                hs_q.push_back(cyc + 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", {22'd0, ch, data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sample", {22'd0, ch, data}, {22'd0, e});
                end
            end
            if (mask_mon && busy && (sel == 2'd0 || sel == 2'd2)) sel_bad++;
        end
        valid_prev <= valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int bad;
        rst_n = 1'b0;
        en    = 1'b0;
        mask  = 4'd0;
        ready = 1'b0;
        set_d(8'd0, 8'd1, 8'd2, 8'd3);
        repeat (3) tick();
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sel_ch_data", {22'd0, sel, ch, data}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Full scan
        mask = 4'b1111;
        ready = 1'b1;
        rise_q.delete();
        hs_q.delete();
        for (int k = 0; k < 5; k++) exp_q.push_back({2'(k % 4), 8'(k % 4)});
        n0 = cyc;
        en = 1'b1;
        drain("full_drain");
        en = 1'b0;
        check("full_first_latency", rise_q[0] - n0, 32'd5);
        for (int k = 0; k < 4; k++) check("full_period", rise_q[k+1] - rise_q[k], SETTLE_CYC + 1);
        tick();
        check("full_abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();

        // Masked scan (pointer is 1 here)
        set_d(8'd4, 8'd5, 8'd6, 8'd7);
        mask = 4'b1010;
        exp_q.push_back({2'd1, 8'd5});
        exp_q.push_back({2'd3, 8'd7});
        exp_q.push_back({2'd1, 8'd5});
        exp_q.push_back({2'd3, 8'd7});
        en = 1'b1;
        tick();
        sel_bad = 0;
        mask_mon = 1'b1;
        drain("masked_drain");
        en = 1'b0;
        tick();
        mask_mon = 1'b0;
        check("masked_sel_never_0_2", sel_bad, 32'd0);
        repeat (3) tick();

        // Backpressure (pointer is 0 here)
        set_d(8'd8, 8'd9, 8'd10, 8'd11);
        mask = 4'b1111;
        rise_q.delete();
        hs_q.delete();
        exp_q.push_back({2'd0, 8'd8});
        exp_q.push_back({2'd1, 8'd9});
        exp_q.push_back({2'd2, 8'd10});
        exp_q.push_back({2'd3, 8'd11});
        en = 1'b1;
        n0 = 0;
        while (!(busy && sel == 2'd2) && n0 < 100) begin
            tick();
            n0++;
        end
        ready = 1'b0;
        wait_valid("bp_valid");
        check("bp_ch", {30'd0, ch}, 32'd2);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_hold_valid", {31'd0, valid}, 32'd1);
            check("bp_hold_data", {24'd0, data}, 32'd10);
            check("bp_hold_sel", {30'd0, sel}, 32'd2);
        end
        ready = 1'b1;
        drain("bp_drain");
        en = 1'b0;
        check("bp_next_latency", rise_q[3] - hs_q[2] + 1, SETTLE_CYC + 1);
        repeat (3) tick();

        // Enable drop mid-SETTLE (pointer is 0 here)
        rise_q.delete();
        en = 1'b1;
        tick();
        tick();
        check("drop_settle_busy_before", {31'd0, busy}, 32'd1);
        en = 1'b0;
        tick();
        check("drop_settle_busy", {31'd0, busy}, 32'd0);
        repeat (8) tick();
        check("drop_settle_no_valid", rise_q.size(), 32'd0);

        // Enable drop during HOLD
        ready = 1'b0;
        exp_q.push_back({2'd0, 8'd8});
        en = 1'b1;
        wait_valid("drop_hold_valid");
        en = 1'b0;
        tick();
        tick();
        check("drop_hold_still_valid", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        tick();
        check("drop_hold_after_hs_valid", {31'd0, valid}, 32'd0);
        check("drop_hold_after_hs_busy", {31'd0, busy}, 32'd0);
        check("drop_hold_popped", exp_q.size(), 32'd0);
        repeat (2) tick();

        // Empty mask, then a single channel (pointer is 1 here)
        mask = 4'd0;
        en = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy || valid) bad++;
        end
        check("empty_mask_idle", bad, 32'd0);
        exp_q.push_back({2'd2, 8'd10});
        mask = 4'b0100;
        drain("one_ch_drain");
        en = 1'b0;
        repeat (3) tick();

        // Asynchronous reset in HOLD
        ready = 1'b0;
        mask = 4'b1000;
        en = 1'b1;
        wait_valid("rst_hold_valid");
        check("rst_hold_data", {24'd0, data}, 32'h0B);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, valid}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_sel_ch_data", {22'd0, sel, ch, data}, 32'd0);
        en = 1'b0;
        repeat (2) tick();
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
